// File: rtl/uart_tx_serializer_if.sv
// Host-side handshake bundle for the UART transmit serializer.
// The host drives start/data; the serializer reports busy/done.
interface uart_tx_serializer_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_start;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_busy;
    logic                 tx_done;

    modport master (
        output tx_start,
        output tx_data,
        input  tx_busy,
        input  tx_done
    );

    modport slave (
        input  tx_start,
        input  tx_data,
        output tx_busy,
        output tx_done
    );
endinterface

// File: rtl/uart_tx_serializer.sv
// UART frame serializer: start bit, LSB-first data, optional parity, 1-2 stop bits.
// Every bit lasts one txclk period; all bit advances happen on txclk rising edges.
module uart_tx_serializer #(
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  txclk,
    uart_tx_serializer_if.slave   bus,
    output logic                  tx
);
    localparam int CW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(DATA_BITS);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } state_t;

    state_t               state_r;
    logic                 txclk_q_r;
    logic [DATA_BITS-1:0] shift_r;
    logic [CW-1:0]        cnt_r;
    logic                 stop_cnt_r;
    logic                 parity_r;
    logic                 tx_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 bit_tick_s;

    function automatic logic calc_parity(input logic [DATA_BITS-1:0] data);
        logic p;
        p = ^data;
        return (PARITY_ODD != 0) ? ~p : p;
    endfunction

    // One-clk pulse on each rising edge of the baud-rate square wave.
    assign bit_tick_s = txclk & ~txclk_q_r;

    // Frame sequencer with registered line and handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            txclk_q_r  <= 1'b0;
            shift_r    <= '0;
            cnt_r      <= '0;
            stop_cnt_r <= 1'b0;
            parity_r   <= 1'b0;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            txclk_q_r <= txclk;
            done_r    <= 1'b0;
            case (state_r)
                IDLE: begin
                    tx_r <= 1'b1;
                    // A tick landing on the accept edge is deliberately dropped;
                    // ARM then waits for the next one so the start bit is full width.
                    if (bus.tx_start) begin
                        shift_r  <= bus.tx_data;
                        parity_r <= calc_parity(bus.tx_data);
                        busy_r   <= 1'b1;
                        state_r  <= ARM;
                    end
                end
                ARM: begin
                    if (bit_tick_s) begin
                        tx_r    <= 1'b0;
                        state_r <= START;
                    end
                end
                START: begin
                    if (bit_tick_s) begin
                        tx_r    <= shift_r[0];
                        shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
                        cnt_r   <= CNT_ONE;
                        state_r <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick_s) begin
                        if (cnt_r < CNT_MAX) begin
                            tx_r    <= shift_r[0];
                            shift_r <= {1'b0, shift_r[DATA_BITS-1:1]};
                            cnt_r   <= cnt_r + CNT_ONE;
                        end else if (PARITY_EN != 0) begin
                            tx_r    <= parity_r;
                            state_r <= PARITY;
                        end else begin
                            tx_r       <= 1'b1;
                            stop_cnt_r <= 1'b0;
                            state_r    <= STOP;
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick_s) begin
                        tx_r       <= 1'b1;
                        stop_cnt_r <= 1'b0;
                        state_r    <= STOP;
                    end
                end
                STOP: begin
                    tx_r <= 1'b1;
                    if (bit_tick_s) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= IDLE;
                        end else begin
                            stop_cnt_r <= stop_cnt_r + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign tx          = tx_r;
    assign bus.tx_busy = busy_r;
    assign bus.tx_done = done_r;
endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench: four serializer configurations (8N1, 8E1, 8O1, 8N2) driven
// from one baud generator with N=8 (bit period 16 clk).
module tb_uart_tx_serializer;
    localparam int PEN [4] = '{0, 1, 1, 0};
    localparam int POD [4] = '{0, 0, 1, 0};
    localparam int STB [4] = '{1, 1, 1, 2};

    logic       clk     = 1'b0;
    logic       rst     = 1'b0;
    logic       txclk   = 1'b0;
    logic       txclk_d = 1'b0;
    int         div_cnt = 0;
    int         cyc     = 0;
    int         checks  = 0;
    int         failures = 0;
    logic [3:0] start_v = 4'b0000;
    logic [7:0] data_a [4];
    logic [3:0] tx_v;
    logic [3:0] busy_v;
    logic [3:0] done_v;
    logic       exp_q [$];

    always #5 clk = ~clk;

    // Baud generator: toggles every 8 clk.
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        txclk_d <= txclk;
        if (div_cnt == 7) begin
            div_cnt <= 0;
            txclk   <= ~txclk;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_serializer_if #(.DATA_BITS(8)) bus_i ();
        assign bus_i.tx_start = start_v[g];
        assign bus_i.tx_data  = data_a[g];
        assign busy_v[g]      = bus_i.tx_busy;
        assign done_v[g]      = bus_i.tx_done;
        uart_tx_serializer #(
            .DATA_BITS (8),
            .PARITY_EN (PEN[g]),
            .PARITY_ODD(POD[g]),
            .STOP_BITS (STB[g])
        ) dut (
            .clk  (clk),
            .rst  (rst),
            .txclk(txclk),
            .bus  (bus_i),
            .tx   (tx_v[g])
        );
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Returns at the negedge just before a clk edge on which the DUT sees a tick.
    task automatic wait_tick(input string tag, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (txclk && !txclk_d) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL %s: no bit tick within 40 clk", tag);
        end
    endtask

    task automatic push_frame(input int sel, input logic [7:0] data);
        logic p;
        exp_q.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(data[i]);
            p = p ^ data[i];
        end
        if (PEN[sel] != 0) exp_q.push_back(POD[sel] != 0 ? ~p : p);
        for (int s = 0; s < STB[sel]; s++) exp_q.push_back(1'b1);
    endtask

    task automatic accept(input int sel, input logic [7:0] data);
        start_v[sel] = 1'b1;
        data_a[sel]  = data;
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        data_a[sel]  = 8'($urandom);
    endtask

    task automatic frame_check(input int sel, input string name, input bit inject,
                               input bit b2b, input logic [7:0] b2b_data, output int t0);
        int   nb;
        bit   ok;
        bit   bad;
        logic e;
        logic got;
        nb  = 9 + PEN[sel] + STB[sel];
        bad = 1'b0;
        ok  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (tx_v[sel] !== 1'b1 || busy_v[sel] !== 1'b1) bad = 1'b1;
            if (txclk && !txclk_d) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (bad || !ok) begin
            failures++;
            $display("FAIL %s arm: tx/busy not held at 1/1 until first tick (tick_seen=%0b)", name, ok);
        end
        @(posedge clk);
        #1;
        t0 = cyc;
        for (int b = 0; b < nb; b++) begin
            e   = exp_q.pop_front();
            got = tx_v[sel];
            bad = 1'b0;
            for (int k = 0; k < 15; k++) begin
                @(negedge clk);
                if (tx_v[sel] !== e || busy_v[sel] !== 1'b1 || done_v[sel] !== 1'b0) bad = 1'b1;
                if (inject && b == 4 && k == 3) begin
                    start_v[sel] = 1'b1;
                    data_a[sel]  = 8'h3C;
                end
                if (inject && b == 4 && k == 4) start_v[sel] = 1'b0;
            end
            checks++;
            if (got !== e || bad) begin
                failures++;
                $display("FAIL %s bit %0d: tx=%b expected=%b (held_ok=%0b)", name, b, got, e, !bad);
            end
            wait_tick(name, ok);
            @(posedge clk);
            #1;
        end
        checks++;
        if (done_v[sel] !== 1'b1 || busy_v[sel] !== 1'b0 || (cyc - t0) != nb * 16) begin
            failures++;
            $display("FAIL %s end: done=%b busy=%b frame_clk=%0d expected done=1 busy=0 frame_clk=%0d",
                     name, done_v[sel], busy_v[sel], cyc - t0, nb * 16);
        end
        if (b2b) begin
            start_v[sel] = 1'b1;
            data_a[sel]  = b2b_data;
        end
        @(posedge clk);
        #1;
        start_v[sel] = 1'b0;
        checks++;
        if (done_v[sel] !== 1'b0 || tx_v[sel] !== 1'b1 || busy_v[sel] !== b2b) begin
            failures++;
            $display("FAIL %s post: done=%b tx=%b busy=%b expected done=0 tx=1 busy=%b",
                     name, done_v[sel], tx_v[sel], busy_v[sel], b2b);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_v !== 4'b1111 || busy_v !== 4'b0000 || done_v !== 4'b0000) begin
            failures++;
            $display("FAIL reset: tx=%b busy=%b done=%b expected 1111/0000/0000", tx_v, busy_v, done_v);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_8n1();
        int t0;
        push_frame(0, 8'hA5);
        accept(0, 8'hA5);
        frame_check(0, "8n1_a5", 1'b0, 1'b0, 8'h00, t0);
    endtask

    task automatic test_parity();
        int t0;
        push_frame(1, 8'hA5);
        accept(1, 8'hA5);
        frame_check(1, "even_a5", 1'b0, 1'b0, 8'h00, t0);
        push_frame(1, 8'h01);
        accept(1, 8'h01);
        frame_check(1, "even_01", 1'b0, 1'b0, 8'h00, t0);
        push_frame(2, 8'hA5);
        accept(2, 8'hA5);
        frame_check(2, "odd_a5", 1'b0, 1'b0, 8'h00, t0);
    endtask

    task automatic test_two_stop();
        int t0;
        push_frame(3, 8'h00);
        accept(3, 8'h00);
        frame_check(3, "2stop_00", 1'b0, 1'b0, 8'h00, t0);
    endtask

    task automatic test_back_to_back();
        int t0;
        bit bad;
        push_frame(0, 8'h5A);
        push_frame(0, 8'hC3);
        accept(0, 8'h5A);
        frame_check(0, "busy_reject_5a", 1'b1, 1'b1, 8'hC3, t0);
        frame_check(0, "b2b_c3", 1'b0, 1'b0, 8'h00, t0);
        bad = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL no_queue: line left idle-high/not-busy after frame, tx=%b busy=%b", tx_v[0], busy_v[0]);
        end
    endtask

    task automatic test_coincident();
        int t0;
        int t_acc;
        bit ok;
        push_frame(0, 8'h96);
        wait_tick("coincident_align", ok);
        accept(0, 8'h96);
        t_acc = cyc;
        frame_check(0, "coincident_96", 1'b0, 1'b0, 8'h00, t0);
        checks++;
        if (t0 - t_acc != 16) begin
            failures++;
            $display("FAIL coincident_latency: start bit %0d clk after accept, expected 16", t0 - t_acc);
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        bit bad;
        accept(0, 8'h00);
        for (int i = 0; i < 3; i++) wait_tick("reset_mid", ok);
        @(posedge clk);
        #1;
        checks++;
        if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_pre: tx=%b busy=%b expected 0/1 during data", tx_v[0], busy_v[0]);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_async: tx=%b busy=%b done=%b expected 1/0/0",
                     tx_v[0], busy_v[0], done_v[0]);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        for (int k = 0; k < 48; k++) begin
            @(negedge clk);
            if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL reset_mid_quiet: line moved after reset release, tx=%b busy=%b", tx_v[0], busy_v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_basic_8n1();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_coincident();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit serializer that sits directly downstream of the TX baud-rate generator.
- Consumes the generator's square-wave txclk and accepts a parallel byte from the host-side logic through a start/busy handshake.
- Shifts out one UART frame LSB-first on the tx line: start bit, data bits, optional parity bit, then 1 or 2 stop bits.
- Each bit lasts exactly one txclk period, so with the generator toggling every N clk the bit time is 2N clk.

Parameters:
- DATA_BITS, 8, number of data bits per frame (5..8).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, used only when PARITY_EN=1; 0 = even parity, 1 = odd parity.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low.
- txclk  input  1  bit-rate square wave from the baud-rate generator, synchronous to clk.
- tx_start  input  1  request to send tx_data; sampled each clk.
- tx_data  input  DATA_BITS  byte to send; captured in the accept cycle.
- tx  output  1  serial line; idle high.
- tx_busy  output  1  high while a frame is in progress.
- tx_done  output  1  one-clk pulse at end of frame.

Behaviour:
- Reset (rst=0, async):
  - tx=1, tx_busy=0, tx_done=0, txclk_q=0, state=IDLE, shift register=0, bit counter=0.
  - Reset mid-frame aborts the frame; tx returns high immediately.
- Bit tick:
  - txclk_q is a register; bit_tick = txclk & ~txclk_q, one clk wide per txclk rising edge.
  - All tx changes and state advances (except accept) occur only on clk edges where bit_tick=1.
- States: IDLE, ARM, START, DATA, PARITY, STOP.
- IDLE:
  - tx=1.
  - Accept when tx_start=1: latch tx_data into shift register; compute parity (XOR of data bits, inverted if PARITY_ODD); go to ARM; tx_busy=1 from the next clk.
  - A bit_tick coincident with the accept is ignored.
- ARM: on bit_tick, tx<=0, go to START. This aligns the start bit to a full bit period.
- START: on bit_tick, tx<=shift[0], shift right by 1, bit counter<=1, go to DATA.
- DATA: on bit_tick:
  - If counter<DATA_BITS: tx<=shift[0], shift, counter++.
  - Else: if PARITY_EN, tx<=parity and go to PARITY; otherwise tx<=1, reset the stop counter, go to STOP.
- PARITY: on bit_tick, tx<=1, go to STOP.
- STOP:
  - Holds tx=1.
  - After STOP_BITS bit_ticks in STOP: go to IDLE, tx_busy<=0, tx_done<=1 for one clk.
- Frame length:
  - 1+DATA_BITS+PARITY_EN+STOP_BITS bit periods, measured from the ARM-exit tick.
  - First-tick latency after accept is at most one txclk period.
- Handshake:
  - tx_start while tx_busy=1 is ignored; no queueing.
  - tx_data need only be valid in the accept cycle.
  - tx_start may be asserted in the same clk that tx_done=1 (state is IDLE) and is accepted, giving back-to-back frames with no idle bit beyond ARM alignment.
- txclk held constant: no ticks, so the FSM stalls in its current state; tx and tx_busy hold.
- Counter widths: bit counter spans 0..DATA_BITS; stop counter is 1 bit.

Test Plan:
- Reset: drive rst=0 mid-frame (tx=0 during data) -> tx=1, tx_busy=0, tx_done=0 within the same cycle; no further tx transitions after rst=1 until tx_start.
- Basic 8N1: generator N=8 (bit period 16 clk), tx_start with tx_data=0xA5 -> tx sequence per bit period 0,1,0,1,0,0,1,0,1,1; tx_busy high throughout; tx_done single pulse; each level held 16 clk.
- Even parity: PARITY_EN=1, PARITY_ODD=0, data=0xA5 -> parity bit 0 after d7; data=0x01 -> parity bit 1. Odd parity, data=0xA5 -> parity bit 1.
- Two stop bits: STOP_BITS=2, data=0x00 -> 0, eight 0s, then 1,1; tx_done fires after the second stop period, 11 bit periods after ARM exit.
- Busy rejection and back-to-back: tx_start=1 with 0x3C mid-frame -> ignored, first frame unchanged; tx_start with 0xC3 in the tx_done cycle -> accepted, second frame start bit begins at the next bit_tick.
- Coincident accept and tick: assert tx_start on the same clk as bit_tick -> tx stays 1 for that tick; start bit begins at the following tick, 16 clk later.
